// File: rtl/while_iter_seq_pkg.sv
// Shared types and the result arithmetic for the clocked unrolled-while block.
// The arithmetic runs at a fixed wide width; callers keep the low NBITS bits.
package while_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned CALC_W = 64;
    typedef logic [CALC_W-1:0] calc_t;

    // The low bits of a wide product/sum equal the truncated narrow result,
    // so callers only need to slice the return value down to their width.
    function automatic calc_t calc_result(calc_t temp, calc_t a, calc_t b, logic mode);
        calc_t prod;
        prod = temp * a;
        return mode ? (prod + b) : (prod - b);
    endfunction

endpackage

// File: rtl/while_iter_seq_if.sv
// Request / result handshake bundle between a requester and while_iter_seq.
interface while_iter_seq_if #(
    parameter int NBITS   = 8,
    parameter int CNTBITS = 4
);
    logic               START;
    logic               READY;
    logic [NBITS-1:0]   A;
    logic [NBITS-1:0]   B;
    logic [CNTBITS-1:0] COUNT;
    logic               MODE;
    logic [NBITS-1:0]   XOUT;
    logic               XVALID;
    logic               XREADY;
    logic               BUSY;

    modport master (
        output START, A, B, COUNT, MODE, XREADY,
        input  READY, XOUT, XVALID, BUSY
    );

    modport slave (
        input  START, A, B, COUNT, MODE, XREADY,
        output READY, XOUT, XVALID, BUSY
    );
endinterface

// File: rtl/while_iter_seq_result_calc.sv
// Combinational trunc(temp*a) +/- b, shared with the combinational loop variant.
module while_result_calc
    import while_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic [NBITS-1:0] temp_i,
    input  logic [NBITS-1:0] a_i,
    input  logic [NBITS-1:0] b_i,
    input  logic             mode_i,
    output logic [NBITS-1:0] res_o
);

    assign res_o = NBITS'(calc_result(calc_t'(temp_i), calc_t'(a_i), calc_t'(b_i), mode_i));

endmodule

// File: rtl/while_iter_seq.sv
// Clocked unrolled-while: temp starts at INIT, gains STEP per cycle COUNT times,
// then trunc(temp*A) -/+ B is presented on a valid/ready output.
module while_iter_seq
    import while_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int CNTBITS = 4,
    parameter int INIT    = 1,
    parameter int STEP    = 1
) (
    input logic           CLK,
    input logic           RST,
    while_iter_seq_if.slave bus
);

    localparam logic [NBITS-1:0] INIT_W = NBITS'(INIT);
    localparam logic [NBITS-1:0] STEP_W = NBITS'(STEP);

    state_t               state_q, state_d;
    logic [NBITS-1:0]     temp_q, temp_d;
    logic [CNTBITS-1:0]   iter_q, iter_d;
    logic [NBITS-1:0]     a_q, a_d;
    logic [NBITS-1:0]     b_q, b_d;
    logic [CNTBITS-1:0]   cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [NBITS-1:0]     xout_q, xout_d;
    logic                 xvalid_q, xvalid_d;
    logic [NBITS-1:0]     calc_res;

    while_result_calc #(.NBITS(NBITS)) u_calc (
        .temp_i (temp_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .mode_i (mode_q),
        .res_o  (calc_res)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            temp_q   <= '0;
            iter_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            xout_q   <= '0;
            xvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            temp_q   <= temp_d;
            iter_q   <= iter_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            xout_q   <= xout_d;
            xvalid_q <= xvalid_d;
        end
    end

    // READY is decoded from IDLE, so START alone qualifies acceptance here.
    always_comb begin
        state_d  = state_q;
        temp_d   = temp_q;
        iter_d   = iter_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        xout_d   = xout_q;
        xvalid_d = xvalid_q;
        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    cnt_d   = bus.COUNT;
                    mode_d  = bus.MODE;
                    temp_d  = INIT_W;
                    iter_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (iter_q != cnt_q) begin
                    temp_d = temp_q + STEP_W;
                    iter_d = iter_q + CNTBITS'(1);
                end else begin
                    xout_d   = calc_res;
                    xvalid_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.XREADY) begin
                    xvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.READY  = (state_q == IDLE);
        bus.BUSY   = (state_q == RUN);
        bus.XOUT   = xout_q;
        bus.XVALID = xvalid_q;
    end

endmodule
